// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch-stage bundle carrying branch/jump controls in and the fetch address out.
//  master: drives stall/ready/ctrl fields and observes the PC outputs.
//  slave : the pc_redirect_unit side.
interface pc_redirect_unit_if;
    logic        stall_i;
    logic        imem_ready_i;
    logic        ctrl_valid_i;
    logic        branch_i;
    logic        zero_i;
    logic        jump_i;
    logic [31:0] ctrl_pc4_i;
    logic [31:0] offset_sl2_i;
    logic [25:0] jump_addr_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        redirect_o;
    modport master (
        output stall_i, imem_ready_i, ctrl_valid_i, branch_i, zero_i, jump_i,
               ctrl_pc4_i, offset_sl2_i, jump_addr_i,
        input  pc_o, pc_plus4_o, fetch_valid_o, redirect_o
    );
    modport slave (
        input  stall_i, imem_ready_i, ctrl_valid_i, branch_i, zero_i, jump_i,
               ctrl_pc4_i, offset_sl2_i, jump_addr_i,
        output pc_o, pc_plus4_o, fetch_valid_o, redirect_o
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump next-PC select and a one-entry redirect buffer.
//  clk_i, rst_i (async, active-high); bus (slave): stall/ready/ctrl inputs, pc_o/pc_plus4_o/
//  fetch_valid_o/redirect_o outputs. Optional BRANCH_COUNT_EN adds taken_cnt_o[15:0].
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC           = 32'h0000_0000,
    parameter bit          BUBBLE_ON_REDIRECT = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef BRANCH_COUNT_EN
    output logic [15:0]       taken_cnt_o,
`endif
    pc_redirect_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, PEND, BUBBLE} state_e;
    state_e      state_q, state_d, after_redirect;
    logic [31:0] pc_q, pc_d, buf_q, buf_d, target;
    logic        started_q, redirect_q, redirect_d, fetch_valid, adv, taken;
    // started_q keeps fetch invalid until the first edge after reset release
    assign fetch_valid       = started_q & (state_q != BUBBLE);
    assign adv               = fetch_valid & bus.imem_ready_i & ~bus.stall_i;
    assign taken             = bus.ctrl_valid_i & (bus.jump_i | (bus.branch_i & bus.zero_i));
    assign target            = bus.jump_i ? {bus.ctrl_pc4_i[31:28], bus.jump_addr_i, 2'b00}
                                          : (bus.ctrl_pc4_i + bus.offset_sl2_i) & 32'hFFFF_FFFC;
    assign after_redirect    = BUBBLE_ON_REDIRECT ? BUBBLE : RUN;
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_q + 32'd4;
    assign bus.fetch_valid_o = fetch_valid;
    assign bus.redirect_o    = redirect_q;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        redirect_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (taken && adv) begin
                    pc_d       = target;
                    redirect_d = 1'b1;
                    state_d    = after_redirect;
                end else if (taken) begin
                    buf_d   = target;
                    state_d = PEND;
                end else if (adv) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PEND: begin
                if (adv) begin
                    pc_d       = buf_q;
                    buf_d      = '0;
                    redirect_d = 1'b1;
                    state_d    = after_redirect;
                end
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            started_q  <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            started_q  <= 1'b1;
            redirect_q <= redirect_d;
        end
    end
`ifdef BRANCH_COUNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) taken_cnt_o <= '0;
        else if (redirect_d && taken_cnt_o != 16'hFFFF) taken_cnt_o <= taken_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and random stimulus against a queue-based fetch model.
module tb_pc_redirect_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    pc_redirect_unit_if bif();
`ifdef BRANCH_COUNT_EN
    logic [15:0] taken_cnt;
`endif
    pc_redirect_unit dut (
        .clk_i(clk),
        .rst_i(rst),
`ifdef BRANCH_COUNT_EN
        .taken_cnt_o(taken_cnt),
`endif
        .bus(bif)
    );
    always #5 clk = ~clk;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    bit          m_started;
    bit          m_redir;
    int          m_bubble;
    int          m_cnt;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".pc"}, bif.pc_o, m_pc);
        chk({tag, ".pc4"}, bif.pc_plus4_o, m_pc + 32'd4);
        chk({tag, ".valid"}, 32'(bif.fetch_valid_o), 32'(m_started && m_bubble == 0));
        chk({tag, ".redir"}, 32'(bif.redirect_o), 32'(m_redir));
`ifdef BRANCH_COUNT_EN
        chk({tag, ".cnt"}, 32'(taken_cnt), 32'(m_cnt));
`endif
    endtask
    task automatic drive(input bit st, input bit rd, input bit cv, input bit br, input bit z,
                         input bit j, input logic [31:0] pc4, input logic [31:0] off,
                         input logic [25:0] ja);
        bif.stall_i = st; bif.imem_ready_i = rd; bif.ctrl_valid_i = cv;
        bif.branch_i = br; bif.zero_i = z; bif.jump_i = j;
        bif.ctrl_pc4_i = pc4; bif.offset_sl2_i = off; bif.jump_addr_i = ja;
    endtask
    task automatic idle(input bit st);
        drive(st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
    endtask
    task automatic apply(input logic [31:0] t);
        m_pc = t;
        m_redir = 1'b1;
        m_bubble = 1;
        if (m_cnt < 65535) m_cnt++;
    endtask
    // Advance the model by one clock using the inputs currently driven, then compare.
    task automatic step(input string tag);
        bit v, adv, taken;
        logic [31:0] tgt;
        v = m_started && m_bubble == 0;
        adv = v && bif.imem_ready_i && !bif.stall_i;
        taken = bif.ctrl_valid_i && (bif.jump_i || (bif.branch_i && bif.zero_i));
        tgt = bif.jump_i ? ((bif.ctrl_pc4_i & 32'hF000_0000) | (32'(bif.jump_addr_i) * 32'd4))
                         : ((bif.ctrl_pc4_i + bif.offset_sl2_i) & 32'hFFFF_FFFC);
        m_redir = 1'b0;
        if (m_bubble > 0) m_bubble--;
        else if (m_pend.size() > 0) begin
            if (adv) apply(m_pend.pop_front());
        end else if (taken) begin
            if (adv) apply(tgt);
            else m_pend.push_back(tgt);
        end else if (adv) m_pc = m_pc + 32'd4;
        m_started = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask
    // Asynchronous reset pulse between edges, checked before any clock edge arrives.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        m_pc = 32'h0; m_pend.delete(); m_started = 1'b0; m_redir = 1'b0; m_bubble = 0; m_cnt = 0;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        idle(1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("t1");
            chk("t1.seq", bif.pc_o, 32'(i * 4));
        end
        drive(0, 1, 1, 0, 0, 1, 32'h10, 32'h0, 26'h40);
        step("t2.jmp");
        chk("t2.jmp_pc", bif.pc_o, 32'h100);
        idle(1'b0);
        step("t2.bub0");
        drive(0, 1, 1, 1, 1, 0, 32'h104, 32'h10, 26'h0);
        step("t2.br");
        chk("t2.br_pc", bif.pc_o, 32'h114);
        chk("t2.br_redir", 32'(bif.redirect_o), 32'd1);
        chk("t2.br_bubble", 32'(bif.fetch_valid_o), 32'd0);
        idle(1'b0);
        step("t2.bub");
        chk("t2.held", bif.pc_o, 32'h114);
        step("t2.next");
        chk("t2.next_pc", bif.pc_o, 32'h118);
        drive(1, 1, 1, 0, 0, 1, 32'h9000_0004, 32'h0, 26'h40);
        step("t3.stall0");
        drive(1, 1, 1, 1, 1, 0, 32'h200, 32'h40, 26'h0);
        step("t3.stall1");
        idle(1'b1);
        step("t3.stall2");
        chk("t3.held", bif.pc_o, 32'h118);
        idle(1'b0);
        step("t3.release");
        chk("t3.target", bif.pc_o, 32'h9000_0100);
        chk("t3.redir", 32'(bif.redirect_o), 32'd1);
        step("t3.bub");
        step("t3.after");
        chk("t3.after_pc", bif.pc_o, 32'h9000_0104);
        drive(0, 1, 1, 1, 0, 0, 32'h40, 32'h40, 26'h0);
        step("t4.nt");
        chk("t4.nt_pc", bif.pc_o, 32'h9000_0108);
        chk("t4.nt_redir", 32'(bif.redirect_o), 32'd0);
        drive(0, 1, 1, 1, 1, 1, 32'h1000_0000, 32'h8, 26'h123);
        step("t4.both");
        chk("t4.both_pc", bif.pc_o, 32'h1000_048C);
        idle(1'b0);
        step("t4.bub");
        drive(0, 1, 1, 0, 0, 1, 32'hF000_0000, 32'h0, 26'h3FF_FFFF);
        step("t5.top");
        chk("t5.top_pc", bif.pc_o, 32'hFFFF_FFFC);
        idle(1'b0);
        step("t5.bub");
        step("t5.wrap");
        chk("t5.wrap_pc", bif.pc_o, 32'h0);
        drive(0, 1, 1, 1, 1, 0, 32'h10, 32'hFFFF_FFF0, 26'h0);
        step("t5.brwrap");
        chk("t5.brwrap_pc", bif.pc_o, 32'h0);
        idle(1'b0);
        step("t5.bub2");
        drive(1, 1, 1, 0, 0, 1, 32'h4, 32'h0, 26'h80);
        step("t6.pend");
        idle(1'b1);
        step("t6.pend2");
        do_reset();
        chk("t6.rst_pc", bif.pc_o, 32'h0);
        chk("t6.rst_redir", 32'(bif.redirect_o), 32'd0);
        idle(1'b0);
        step("t6.start");
        step("t6.run");
        chk("t6.run_pc", bif.pc_o, 32'h4);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 1, 32'h0, 32'h0, 26'(i * 16 + 16));
            step("t6.j");
            idle(1'b0);
            step("t6.jbub");
        end
`ifdef BRANCH_COUNT_EN
        chk("t6.cnt3", 32'(taken_cnt), 32'd3);
`endif
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                  1'($urandom), 1'($urandom), $urandom_range(0, 9) < 3,
                  $urandom, $urandom, 26'($urandom));
            if ($urandom_range(0, 99) == 0) do_reset();
            step("rnd");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
